// File: rtl/ov_cfg_pkg.sv
// Shared types and constants for the OV7670 register configuration sequencer.
// OV_CFG_READBACK_EN adds the RbIssue/RbWait states used for write verification.
package ov_cfg_pkg;

    localparam logic [7:0] TAG_END   = 8'hFF;
    localparam logic [7:0] TAG_DELAY = 8'hFE;
    localparam logic [7:0] REG_COM7  = 8'h12;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] val;
    } cfg_entry_t;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWait,
        StDelay,
        StNext,
        StFail,
        StFinish,
        StError
`ifdef OV_CFG_READBACK_EN
        ,
        StRbIssue,
        StRbWait
`endif
    } state_e;

    // COM7 soft-resets the sensor, so its register cannot be read back reliably.
    function automatic logic readback_exempt(input logic [7:0] reg_addr);
        return reg_addr == REG_COM7;
    endfunction

endpackage

// File: rtl/ov_cfg_sequencer_if.sv
// Command/response channel between the configuration sequencer and the SCCB byte master.
interface ov_cfg_sequencer_if;

    logic       M_VALID;
    logic       M_READY;
    logic       M_RW;
    logic [7:0] M_DEV;
    logic [7:0] M_REG;
    logic [7:0] M_WDATA;
    logic       M_DONE;
    logic       M_NACK;
    logic [7:0] M_RDATA;

    modport master (
        output M_VALID, M_RW, M_DEV, M_REG, M_WDATA,
        input  M_READY, M_DONE, M_NACK, M_RDATA
    );

    modport slave (
        input  M_VALID, M_RW, M_DEV, M_REG, M_WDATA,
        output M_READY, M_DONE, M_NACK, M_RDATA
    );

endinterface

// File: rtl/ov_cfg_rom.sv
// Synchronous-read OV7670 configuration table: {reg, val} per entry, 8'hFF reg ends it.
module ov_cfg_rom
    import ov_cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic [7:0] addr_i,
    output cfg_entry_t entry_o
);

    cfg_entry_t rom_data;
    cfg_entry_t entry_q;

    always_comb begin
        rom_data = '{reg_addr: TAG_END, val: 8'hFF};
        case (addr_i)
            8'd0:    rom_data = '{reg_addr: REG_COM7,  val: 8'h80};
            // Let the sensor settle after its soft reset.
            8'd1:    rom_data = '{reg_addr: TAG_DELAY, val: 8'h0A};
            8'd2:    rom_data = '{reg_addr: 8'h11,     val: 8'h01};
            8'd3:    rom_data = '{reg_addr: TAG_END,   val: 8'h00};
            default: rom_data = '{reg_addr: TAG_END,   val: 8'hFF};
        endcase
    end

    always_ff @(posedge clk_i) begin
        entry_q <= rom_data;
    end

    assign entry_o = entry_q;

endmodule

// File: rtl/ov_cfg_sequencer.sv
// Walks the OV7670 config table, issuing one SCCB write per entry with delays and retries.
// Defining OV_CFG_READBACK_EN verifies each write (except COM7) with a read of the same register.
module ov_cfg_sequencer
    import ov_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned TABLE_DEPTH = 256,
    parameter int unsigned MAX_RETRY   = 3,
    parameter logic [7:0]  DEV_ADDR    = 8'h42
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      START,
    output logic                      BUSY,
    output logic                      DONE,
    output logic                      ERR,
    output logic [7:0]                ERR_INDEX,
    ov_cfg_sequencer_if.master        sccb_io
);

    localparam int unsigned TicksPerMs = (CLK_FREQ_HZ / 1000 > 0) ? CLK_FREQ_HZ / 1000 : 1;
    localparam int unsigned TickW      = (TicksPerMs > 1) ? $clog2(TicksPerMs) : 1;
    localparam int unsigned RetryW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TickW-1:0]  TickLast  = TickW'(TicksPerMs - 1);
    localparam logic [RetryW-1:0] RetryMax  = RetryW'(MAX_RETRY);
    localparam logic [7:0]        LastIndex = 8'(TABLE_DEPTH - 1);

    state_e            state_q, state_d;
    logic [7:0]        index_q, index_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        err_index_q, err_index_d;
    logic              valid_q, valid_d;
    logic              rw_q, rw_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        ms_left_q, ms_left_d;
    logic [TickW-1:0]  tick_q, tick_d;

    cfg_entry_t        entry;

    ov_cfg_rom u_rom (
        .clk_i   (CLK),
        .addr_i  (index_q),
        .entry_o (entry)
    );

`ifndef OV_CFG_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^sccb_io.M_RDATA;
`endif

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_index_d = err_index_q;
        rw_d        = rw_q;
        reg_d       = reg_q;
        wdata_d     = wdata_q;
        ms_left_d   = ms_left_q;
        tick_d      = tick_q;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    state_d = StFetch;
                    index_d = 8'd0;
                    retry_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                if (entry.reg_addr == TAG_END) begin
                    state_d = StFinish;
                end else if (entry.reg_addr == TAG_DELAY) begin
                    state_d   = (entry.val == 8'd0) ? StNext : StDelay;
                    ms_left_d = entry.val;
                    tick_d    = '0;
                end else begin
                    state_d = StIssue;
                    reg_d   = entry.reg_addr;
                    wdata_d = entry.val;
                    rw_d    = 1'b0;
                end
            end
            StIssue: begin
                if (sccb_io.M_READY) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (sccb_io.M_DONE) begin
                    if (sccb_io.M_NACK) begin
                        state_d = StFail;
`ifdef OV_CFG_READBACK_EN
                    end else if (!readback_exempt(reg_q)) begin
                        state_d = StRbIssue;
                        rw_d    = 1'b1;
`endif
                    end else begin
                        state_d = StNext;
                    end
                end
            end
`ifdef OV_CFG_READBACK_EN
            StRbIssue: begin
                if (sccb_io.M_READY) begin
                    state_d = StRbWait;
                end
            end
            StRbWait: begin
                if (sccb_io.M_DONE) begin
                    if (sccb_io.M_NACK || (sccb_io.M_RDATA != wdata_q)) begin
                        state_d = StFail;
                    end else begin
                        state_d = StNext;
                    end
                end
            end
`endif
            StDelay: begin
                if (tick_q == TickLast) begin
                    tick_d = '0;
                    if (ms_left_q == 8'd1) begin
                        state_d = StNext;
                    end else begin
                        ms_left_d = ms_left_q - 8'd1;
                    end
                end else begin
                    tick_d = tick_q + TickW'(1);
                end
            end
            StNext: begin
                if (index_q == LastIndex) begin
                    state_d = StFinish;
                end else begin
                    state_d = StFetch;
                    index_d = index_q + 8'd1;
                    retry_d = '0;
                end
            end
            StFail: begin
                // A retry always restarts from the write, even if only the readback failed.
                if (retry_q < RetryMax) begin
                    state_d = StIssue;
                    retry_d = retry_q + RetryW'(1);
                    rw_d    = 1'b0;
                end else begin
                    state_d = StError;
                end
            end
            StFinish: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            StError: begin
                state_d     = StIdle;
                busy_d      = 1'b0;
                err_d       = 1'b1;
                err_index_d = index_q;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef OV_CFG_READBACK_EN
    assign valid_d = (state_d == StIssue) || (state_d == StRbIssue);
`else
    assign valid_d = (state_d == StIssue);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            index_q     <= 8'd0;
            retry_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= 8'd0;
            valid_q     <= 1'b0;
            rw_q        <= 1'b0;
            reg_q       <= 8'd0;
            wdata_q     <= 8'd0;
            ms_left_q   <= 8'd0;
            tick_q      <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
            valid_q     <= valid_d;
            rw_q        <= rw_d;
            reg_q       <= reg_d;
            wdata_q     <= wdata_d;
            ms_left_q   <= ms_left_d;
            tick_q      <= tick_d;
        end
    end

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign ERR             = err_q;
    assign ERR_INDEX       = err_index_q;
    assign sccb_io.M_VALID = valid_q;
    assign sccb_io.M_RW    = rw_q;
    assign sccb_io.M_DEV   = DEV_ADDR;
    assign sccb_io.M_REG   = reg_q;
    assign sccb_io.M_WDATA = wdata_q;

endmodule

// File: tb/tb_ov_cfg_sequencer.sv
// Scoreboard bench for ov_cfg_sequencer with a behavioural SCCB master that answers after 10 cycles.
module tb_ov_cfg_sequencer;

    localparam int unsigned ClkHz     = 10000;  // 10 cycles per ms keeps delay entries short
    localparam int          AckCycles = 10;
`ifdef OV_CFG_READBACK_EN
    localparam bit Rb = 1'b1;
`else
    localparam bit Rb = 1'b0;
`endif

    typedef struct {
        bit         rw;
        logic [7:0] rg;
        logic [7:0] wd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, err;
    logic [7:0] err_index;

    ov_cfg_sequencer_if sccb ();

    ov_cfg_sequencer #(
        .CLK_FREQ_HZ (ClkHz),
        .TABLE_DEPTH (256),
        .MAX_RETRY   (3),
        .DEV_ADDR    (8'h42)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .ERR_INDEX (err_index),
        .sccb_io   (sccb)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    exp_t       exp_q[$];
    int         cyc = 0;
    int         n_txn = 0;
    int         t12 = -1;
    int         t11 = -1;
    bit         acc_pend = 1'b0;
    bit         prev_acc = 1'b0;
    bit         acc_rw;
    logic [7:0] acc_reg, acc_wd;
    int         busy_cnt = 0;
    int         stall_left = 0;
    int         stall_seen = 0;
    bit         stall_bad = 1'b0;
    logic [7:0] stall_reg, stall_wd;
    int         nack_left = 0;
    bit         nack_always = 1'b0;
    bit         rd_corrupt = 1'b0;
    logic [7:0] mem [256];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [7:0] rg, input logic [7:0] wd);
        exp_t e;
        e.rw = 1'b0; e.rg = rg; e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic push_r(input logic [7:0] rg);
        exp_t e;
        e.rw = 1'b1; e.rg = rg; e.wd = 8'h00;
        exp_q.push_back(e);
    endtask

    // Command side: detect handshakes and score them against the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (prev_acc) begin
                prev_acc = 1'b0;
                check_eq("valid_drop", 32'(sccb.M_VALID), 0);
            end
            if (rst !== 1'b1 && sccb.M_VALID === 1'b1) begin
                if (sccb.M_READY === 1'b1) begin
                    exp_t e;
                    acc_pend = 1'b1;
                    prev_acc = 1'b1;
                    acc_rw   = sccb.M_RW;
                    acc_reg  = sccb.M_REG;
                    acc_wd   = sccb.M_WDATA;
                    n_txn++;
                    if (!acc_rw && acc_reg == 8'h12) t12 = cyc;
                    if (!acc_rw && acc_reg == 8'h11 && t11 < 0) t11 = cyc;
                    check_eq("sb_has_entry", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("txn_rw", 32'(acc_rw), 32'(e.rw));
                        check_eq("txn_reg", 32'(acc_reg), 32'(e.rg));
                        check_eq("txn_dev", 32'(sccb.M_DEV), 'h42);
                        if (!e.rw) check_eq("txn_wdata", 32'(acc_wd), 32'(e.wd));
                    end
                end else if (stall_left > 0) begin
                    if (stall_seen == 0) begin
                        stall_reg = sccb.M_REG;
                        stall_wd  = sccb.M_WDATA;
                    end else if (sccb.M_REG !== stall_reg || sccb.M_WDATA !== stall_wd) begin
                        stall_bad = 1'b1;
                    end
                    stall_seen++;
                    stall_left--;
                end
            end
        end
    end

    // Response side: READY when idle, M_DONE AckCycles after acceptance.
    initial begin
        sccb.M_READY = 1'b0;
        sccb.M_DONE  = 1'b0;
        sccb.M_NACK  = 1'b0;
        sccb.M_RDATA = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            sccb.M_DONE = 1'b0;
            sccb.M_NACK = 1'b0;
            if (rst === 1'b1) begin
                acc_pend = 1'b0;
                busy_cnt = 0;
            end else if (acc_pend) begin
                acc_pend = 1'b0;
                busy_cnt = AckCycles;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bit nack;
                    nack = !acc_rw && acc_reg == 8'h11 && (nack_always || nack_left > 0);
                    if (nack && !nack_always) nack_left--;
                    if (!acc_rw && !nack) mem[acc_reg] = acc_wd;
                    if (acc_rw) sccb.M_RDATA = rd_corrupt ? 8'h00 : mem[acc_reg];
                    sccb.M_DONE = 1'b1;
                    sccb.M_NACK = nack;
                end
            end
            sccb.M_READY = (busy_cnt == 0) && !acc_pend && (stall_left <= 0);
        end
    end

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input bit pulse);
        bit ended = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done || err) begin
                ended = 1'b1;
                break;
            end
            start = pulse && (i % 25 == 7);
        end
        start = 1'b0;
        check_eq("pass_end", 32'(ended), 1);
    endtask

    initial begin
        int n_before;
        bit reached;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_err", 32'(err), 0);
        check_eq("rst_err_index", 32'(err_index), 0);
        check_eq("rst_valid", 32'(sccb.M_VALID), 0);
        check_eq("rst_rw", 32'(sccb.M_RW), 0);
        check_eq("rst_dev", 32'(sccb.M_DEV), 'h42);
        check_eq("rst_reg", 32'(sccb.M_REG), 0);
        check_eq("rst_wdata", 32'(sccb.M_WDATA), 0);
        rst = 1'b0;

        // Clean pass with START-to-M_VALID latency.
        push_w(8'h12, 8'h80);
        push_w(8'h11, 8'h01);
        if (Rb) push_r(8'h11);
        start_pass();
        check_eq("busy_rise", 32'(busy), 1);
        check_eq("valid_fetch", 32'(sccb.M_VALID), 0);
        @(negedge clk);
        check_eq("valid_decode", 32'(sccb.M_VALID), 0);
        @(negedge clk);
        check_eq("first_valid", 32'(sccb.M_VALID), 1);
        wait_end(1'b0);
        check_eq("clean_done", 32'(done), 1);
        check_eq("clean_busy", 32'(busy), 0);
        check_eq("clean_err", 32'(err), 0);
        check_eq("clean_sb_empty", 32'(exp_q.size()), 0);
        // 11 ack + NEXT/FETCH/DECODE + 100 delay cycles + NEXT/FETCH/DECODE/ISSUE
        check_eq("delay_gap", 32'(t11 - t12), 118);

        // Two NACKs on reg 11, then ACK.
        nack_left = 2;
        push_w(8'h12, 8'h80);
        repeat (3) push_w(8'h11, 8'h01);
        if (Rb) push_r(8'h11);
        start_pass();
        check_eq("done_clr", 32'(done), 0);
        wait_end(1'b0);
        check_eq("retry_done", 32'(done), 1);
        check_eq("retry_err", 32'(err), 0);
        check_eq("retry_sb_empty", 32'(exp_q.size()), 0);
        check_eq("retry_nacks_used", 32'(nack_left), 0);

        // Permanent NACK on reg 11.
        nack_always = 1'b1;
        push_w(8'h12, 8'h80);
        repeat (4) push_w(8'h11, 8'h01);
        start_pass();
        wait_end(1'b0);
        check_eq("abort_err", 32'(err), 1);
        check_eq("abort_err_index", 32'(err_index), 2);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_sb_empty", 32'(exp_q.size()), 0);
        nack_always = 1'b0;

        // READY held low for 50 cycles on the first command.
        stall_left = 50;
        stall_seen = 0;
        stall_bad  = 1'b0;
        push_w(8'h12, 8'h80);
        push_w(8'h11, 8'h01);
        if (Rb) push_r(8'h11);
        start_pass();
        check_eq("err_clr", 32'(err), 0);
        wait_end(1'b0);
        check_eq("stall_cycles", 32'(stall_seen), 50);
        check_eq("stall_stable", 32'(stall_bad), 0);
        check_eq("stall_done", 32'(done), 1);
        check_eq("stall_sb_empty", 32'(exp_q.size()), 0);

        // Extra START pulses during a pass are ignored.
        n_before = n_txn;
        push_w(8'h12, 8'h80);
        push_w(8'h11, 8'h01);
        if (Rb) push_r(8'h11);
        start_pass();
        wait_end(1'b1);
        repeat (30) @(negedge clk);
        check_eq("one_pass_txns", 32'(n_txn - n_before), Rb ? 3 : 2);
        check_eq("one_pass_done", 32'(done), 1);
        check_eq("one_pass_busy", 32'(busy), 0);
        check_eq("one_pass_sb_empty", 32'(exp_q.size()), 0);

        // RST while waiting for M_DONE.
        push_w(8'h12, 8'h80);
        start_pass();
        reached = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy_cnt > 0) begin
                reached = 1'b1;
                break;
            end
        end
        check_eq("reach_wait", 32'(reached), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_wait_valid", 32'(sccb.M_VALID), 0);
        check_eq("rst_wait_busy", 32'(busy), 0);
        check_eq("rst_wait_done", 32'(done), 0);
        rst = 1'b0;

        // RST while M_VALID is held against a stalled master.
        stall_left = 1000;
        start_pass();
        repeat (3) @(negedge clk);
        check_eq("stall_valid_high", 32'(sccb.M_VALID), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_issue_valid", 32'(sccb.M_VALID), 0);
        check_eq("rst_issue_busy", 32'(busy), 0);
        rst        = 1'b0;
        stall_left = 0;

        // A fresh START after reset walks the table from index 0.
        push_w(8'h12, 8'h80);
        push_w(8'h11, 8'h01);
        if (Rb) push_r(8'h11);
        start_pass();
        wait_end(1'b0);
        check_eq("restart_done", 32'(done), 1);
        check_eq("restart_sb_empty", 32'(exp_q.size()), 0);

`ifdef OV_CFG_READBACK_EN
        // Readback never matches reg 11: four write/read pairs, then abort.
        rd_corrupt = 1'b1;
        push_w(8'h12, 8'h80);
        repeat (4) begin
            push_w(8'h11, 8'h01);
            push_r(8'h11);
        end
        start_pass();
        wait_end(1'b0);
        check_eq("rb_err", 32'(err), 1);
        check_eq("rb_err_index", 32'(err_index), 2);
        check_eq("rb_done", 32'(done), 0);
        check_eq("rb_sb_empty", 32'(exp_q.size()), 0);
        rd_corrupt = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
